npc_arb: RTL and testbench
==========================

// Module: npc_arb
// PURPOSE
//  Round-robin arbiter sharing one npc burst port between N interpreter masters.
//  Each master uses the npc handshake: req held until a 1-cycle gnt, then len acks.
//  Sits between the interpreter instances and the single npc port.
//  Owns the downstream port for one whole burst: request, grant, then len acks.
// PARAMETERS
//  N        4    number of requesters (2..8)
//  WD_CYC   1024 watchdog limit: idle cycles without an ack (NPC_ARB_WDOG_EN only)
// PORTS
//  clk      in   1     clock
//  rstn     in   1     reset, asynchronous, active-low
//  s_req    in   N     per-master request
//  s_gnt    out  N     per-master grant pulse
//  s_rwn    in   N     per-master read(1)/write(0)
//  s_adr    in   32*N  per-master address, master i at [32*i+:32]
//  s_len    in   32*N  per-master burst length in words
//  s_wdt    in   32*N  per-master write data
//  s_rdt    out  32    read data broadcast to all masters
//  s_ack    out  N     per-master ack, only the owner's bit can be 1
//  m_req    out  1     npc request
//  m_gnt    in   1     npc grant
//  m_rwn    out  1     latched rwn of owner
//  m_adr    out  32    latched adr of owner
//  m_len    out  32    latched len of owner
//  m_wdt    out  32    owner's s_wdt, combinational mux
//  m_rdt    in   32    npc read data
//  m_ack    in   1     npc ack, one per word
//  own      out  N     one-hot current owner, 0 when IDLE
//  wd_err   out  1     watchdog abort pulse; tied 0 without the macro
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, own=0, m_req=0, m_rwn/m_adr/m_len=0, acnt=0, wd_err=0.
//  Reset mid-burst aborts at once. No acks are forwarded after reset.
//  States: IDLE -> REQ -> XFER -> IDLE.
//  IDLE:
//   - If any s_req: pick the first set bit scanning ptr, ptr+1, ... mod N.
//   - Latch its rwn/adr/len, set own, acnt=0, go to REQ.
//   - Winner is chosen one cycle after req is seen (1-cycle arbitration latency).
//  REQ:
//   - m_req=1, driven combinationally from state.
//   - s_gnt[own] = m_gnt, combinational; all other gnt bits are 0.
//   - On m_gnt: go to XFER, or to IDLE if latched len==0.
//   - On m_gnt: ptr = owner index + 1 mod N.
//  XFER:
//   - m_req=0.
//   - s_ack[own] = m_ack, combinational; s_rdt = m_rdt always.
//   - m_wdt = s_wdt[own] in every state (0 in IDLE).
//   - Each m_ack increments acnt.
//   - The ack with acnt==len-1 returns to IDLE; own clears the next cycle.
//  Back-to-back: IDLE re-arbitrates on the cycle after the last ack.
//   - Minimum gap between bursts = 1 IDLE cycle.
//  s_req is sampled only in IDLE; dropping req in REQ has no effect; the burst runs to completion.
//  m_ack outside XFER is ignored: no s_ack, no counting.
//  m_gnt outside REQ is ignored.
//  acnt is 32 bits; len is taken as unsigned, so no wrap is possible for legal lengths.
// CONFIGURATION
//  NPC_ARB_WDOG_EN defined:
//   - A 32-bit timer counts in XFER; it clears on each m_ack and on entry to XFER.
//   - On reaching WD_CYC: wd_err=1 for 1 cycle, state goes to IDLE, and own is released.
//   - The owner gets no further acks.
//  NPC_ARB_WDOG_EN undefined:
//   - No timer; wd_err is tied 0; XFER waits for acks indefinitely.
// TESTING
//  1) s_req=0001, len=4, rd; npc gnt after 3 cyc, 4 acks -> s_gnt[0] 1 pulse, 4 s_ack[0], own back to 0.
//  2) s_req=1111 held, len=1 each -> grant order 0,1,2,3,0; each owner's adr appears on m_adr.
//  3) Master 2 writes len=3, s_wdt changes each ack -> m_wdt tracks s_wdt[2]; s_ack[0,1,3]=0.
//  4) len=0 from master 1 -> gnt pulse, no ack, IDLE next cycle, ptr=2.
//  5) rstn low during XFER acnt=2 -> own=0, m_req=0 at once; later m_ack gives no s_ack.
//  6) WDOG_EN, WD_CYC=16, ack stalls after 1 word -> wd_err pulse 16 cycles later; next master granted.

Source files
------------

// File: rtl/npc_arb.sv
// npc_arb: round-robin owner of the single npc burst port; 1-cycle arbitration, holds the port for req/gnt/len acks.
// Masters wait on gnt/ack while another burst runs; optional stall watchdog under NPC_ARB_WDOG_EN.
module npc_arb #(
    parameter int N      = 4,
    parameter int WD_CYC = 1024
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N-1:0]    s_req,
    output logic [N-1:0]    s_gnt,
    input  logic [N-1:0]    s_rwn,
    input  logic [32*N-1:0] s_adr,
    input  logic [32*N-1:0] s_len,
    input  logic [32*N-1:0] s_wdt,
    output logic [31:0]     s_rdt,
    output logic [N-1:0]    s_ack,
    output logic            m_req,
    input  logic            m_gnt,
    output logic            m_rwn,
    output logic [31:0]     m_adr,
    output logic [31:0]     m_len,
    output logic [31:0]     m_wdt,
    input  logic [31:0]     m_rdt,
    input  logic            m_ack,
    output logic [N-1:0]    own,
    output logic            wd_err
);
    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER} state_t;

    state_t        r_state;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_own_idx;
    logic [N-1:0]  r_own;
    logic          r_rwn;
    logic [31:0]   r_adr;
    logic [31:0]   r_len;
    logic [31:0]   r_acnt;

    logic [PW-1:0] w_pick;
    logic [PW-1:0] w_ptr_nxt;
    logic          w_last;
    logic          w_wd_hit;

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        w_pick = r_ptr;
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = int'(r_ptr) + k;
            if (j >= N) j = j - N;
            if (s_req[j]) w_pick = PW'(j);
        end
    end

    assign w_ptr_nxt = (r_own_idx == PW'(N - 1)) ? '0 : r_own_idx + PW'(1);
    assign w_last    = (r_acnt == r_len - 32'd1);

    assign m_req  = (r_state == ST_REQ);
    assign s_gnt  = (r_state == ST_REQ  && m_gnt) ? r_own : '0;
    assign s_ack  = (r_state == ST_XFER && m_ack) ? r_own : '0;
    assign s_rdt  = m_rdt;
    assign m_wdt  = (r_state == ST_IDLE) ? 32'd0 : s_wdt[32*r_own_idx +: 32];
    assign m_rwn  = r_rwn;
    assign m_adr  = r_adr;
    assign m_len  = r_len;
    assign own    = r_own;

`ifdef NPC_ARB_WDOG_EN
    logic [31:0] r_wd_cnt;
    logic        r_wd_err;

    assign w_wd_hit = (r_state == ST_XFER) && !m_ack && (r_wd_cnt == 32'(WD_CYC - 1));
    assign wd_err   = r_wd_err;

    // Timer is held at zero outside XFER, so entry into XFER starts it clean.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wd_cnt <= '0;
            r_wd_err <= 1'b0;
        end else begin
            r_wd_err <= w_wd_hit;
            if (r_state != ST_XFER || m_ack || w_wd_hit)
                r_wd_cnt <= '0;
            else
                r_wd_cnt <= r_wd_cnt + 32'd1;
        end
    end
`else
    assign w_wd_hit = 1'b0;
    assign wd_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_own_idx <= '0;
            r_own     <= '0;
            r_rwn     <= 1'b0;
            r_adr     <= '0;
            r_len     <= '0;
            r_acnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|s_req) begin
                        r_state   <= ST_REQ;
                        r_own_idx <= w_pick;
                        r_own     <= {{(N-1){1'b0}}, 1'b1} << w_pick;
                        r_rwn     <= s_rwn[w_pick];
                        r_adr     <= s_adr[32*w_pick +: 32];
                        r_len     <= s_len[32*w_pick +: 32];
                        r_acnt    <= '0;
                    end
                end
                ST_REQ: begin
                    if (m_gnt) begin
                        r_ptr <= w_ptr_nxt;
                        if (r_len == 32'd0) begin
                            r_state <= ST_IDLE;
                            r_own   <= '0;
                        end else begin
                            r_state <= ST_XFER;
                        end
                    end
                end
                ST_XFER: begin
                    if (m_ack) begin
                        r_acnt <= r_acnt + 32'd1;
                        if (w_last) begin
                            r_state <= ST_IDLE;
                            r_own   <= '0;
                        end
                    end else if (w_wd_hit) begin
                        r_state <= ST_IDLE;
                        r_own   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_own   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npc_arb.sv
// Directed bench for npc_arb: scoreboard queues of expected grants and acks, checked at the falling edge.
module tb_npc_arb;
    localparam int N = 4;
    localparam logic [N-1:0] ONE = 1;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    s_req;
    logic [N-1:0]    s_gnt;
    logic [N-1:0]    s_rwn;
    logic [32*N-1:0] s_adr;
    logic [32*N-1:0] s_len;
    logic [32*N-1:0] s_wdt;
    logic [31:0]     s_rdt;
    logic [N-1:0]    s_ack;
    logic            m_req;
    logic            m_gnt;
    logic            m_rwn;
    logic [31:0]     m_adr;
    logic [31:0]     m_len;
    logic [31:0]     m_wdt;
    logic [31:0]     m_rdt;
    logic            m_ack;
    logic [N-1:0]    own;
    logic            wd_err;

    always #5 clk = ~clk;

    npc_arb #(.N(N), .WD_CYC(16)) dut (
        .clk(clk), .rstn(rstn),
        .s_req(s_req), .s_gnt(s_gnt), .s_rwn(s_rwn), .s_adr(s_adr), .s_len(s_len),
        .s_wdt(s_wdt), .s_rdt(s_rdt), .s_ack(s_ack),
        .m_req(m_req), .m_gnt(m_gnt), .m_rwn(m_rwn), .m_adr(m_adr), .m_len(m_len),
        .m_wdt(m_wdt), .m_rdt(m_rdt), .m_ack(m_ack),
        .own(own), .wd_err(wd_err)
    );

    typedef struct {
        logic [N-1:0] own;
        logic [31:0]  adr;
        logic [31:0]  len;
        logic         rwn;
    } gnt_exp_t;

    typedef struct {
        logic [N-1:0] own;
        logic [31:0]  rdt;
        logic [31:0]  wdt;
    } ack_exp_t;

    gnt_exp_t gq[$];
    ack_exp_t aq[$];
    int vectors     = 0;
    int miscompares = 0;
    int ack_cnt[N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        gnt_exp_t g;
        ack_exp_t a;
        if (|s_gnt) begin
            if (gq.size() == 0) begin
                check("gnt_unexpected", 64'(s_gnt), 64'd0);
            end else begin
                g = gq.pop_front();
                check("gnt_onehot", 64'(s_gnt), 64'(g.own));
                check("m_adr", 64'(m_adr), 64'(g.adr));
                check("m_len", 64'(m_len), 64'(g.len));
                check("m_rwn", 64'(m_rwn), 64'(g.rwn));
            end
        end
        if (|s_ack) begin
            for (int i = 0; i < N; i++) if (s_ack[i]) ack_cnt[i]++;
            if (aq.size() == 0) begin
                check("ack_unexpected", 64'(s_ack), 64'd0);
            end else begin
                a = aq.pop_front();
                check("ack_onehot", 64'(s_ack), 64'(a.own));
                check("s_rdt", 64'(s_rdt), 64'(a.rdt));
                check("m_wdt", 64'(m_wdt), 64'(a.wdt));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int i, input logic rwn, input logic [31:0] adr, input logic [31:0] len);
        s_rwn[i]         = rwn;
        s_adr[32*i +: 32] = adr;
        s_len[32*i +: 32] = len;
    endtask

    task automatic npc_grant(input int owner, input int delay, input bit drop, output int waited);
        gnt_exp_t g;
        waited = 0;
        while (!m_req && waited < 50) begin
            tick();
            waited++;
        end
        check("m_req_seen", 64'(m_req), 64'd1);
        if (m_req) begin
            repeat (delay) tick();
            g.own = ONE << owner;
            g.adr = s_adr[32*owner +: 32];
            g.len = s_len[32*owner +: 32];
            g.rwn = s_rwn[owner];
            gq.push_back(g);
            m_gnt = 1'b1;
            tick();
            m_gnt = 1'b0;
            if (drop) s_req[owner] = 1'b0;
        end
    endtask

    task automatic npc_acks(input int owner, input int n, input int gap);
        ack_exp_t a;
        for (int k = 0; k < n; k++) begin
            repeat (gap) tick();
            m_rdt = $urandom;
            s_wdt[32*owner +: 32] = $urandom;
            a.own = ONE << owner;
            a.rdt = m_rdt;
            a.wdt = s_wdt[32*owner +: 32];
            aq.push_back(a);
            m_ack = 1'b1;
            tick();
            m_ack = 1'b0;
        end
        check("acks_consumed", 64'(aq.size()), 64'd0);
    endtask

    initial begin
        int w;
        int order2[5];
        int order4[3];
        int base0;
        int wd_t;
        bit wd_seen;

        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
        rstn  = 1'b0;
        s_req = '0; s_rwn = '0; s_adr = '0; s_len = '0; s_wdt = '1;
        m_gnt = 1'b0; m_rdt = '0;
        m_ack = 1'b1;
        tick(); tick();
        check("rst_own", 64'(own), 64'd0);
        check("rst_m_req", 64'(m_req), 64'd0);
        check("rst_m_rwn", 64'(m_rwn), 64'd0);
        check("rst_m_adr", 64'(m_adr), 64'd0);
        check("rst_m_len", 64'(m_len), 64'd0);
        check("rst_wd_err", 64'(wd_err), 64'd0);
        check("rst_s_ack", 64'(s_ack), 64'd0);
        check("idle_m_wdt", 64'(m_wdt), 64'd0);
        m_ack = 1'b0;
        rstn  = 1'b1;

        // 1) single read burst, len 4, late grant
        set_master(0, 1'b1, 32'h0000_1000, 32'd4);
        s_req = 4'b0001;
        check("arb_latency_0", 64'(m_req), 64'd0);
        tick();
        check("arb_latency_1", 64'(m_req), 64'd1);
        check("own_req", 64'(own), 64'b0001);
        npc_grant(0, 3, 1'b1, w);
        check("own_xfer", 64'(own), 64'b0001);
        check("m_req_xfer", 64'(m_req), 64'd0);
        npc_acks(0, 4, 0);
        check("own_released", 64'(own), 64'd0);
        check("t1_ack_cnt", 64'(ack_cnt[0]), 64'd4);

        // stray npc handshakes while idle are ignored
        m_ack = 1'b1; m_gnt = 1'b1;
        check("idle_no_ack", 64'(s_ack), 64'd0);
        check("idle_no_gnt", 64'(s_gnt), 64'd0);
        tick();
        m_ack = 1'b0; m_gnt = 1'b0;
        check("idle_stays", 64'(m_req), 64'd0);
        check("idle_own", 64'(own), 64'd0);

        // 2) all four held, len 1 each, from ptr 0
        rstn = 1'b0; tick(); rstn = 1'b1;
        for (int i = 0; i < N; i++) set_master(i, 1'b1, 32'h2000 + 32'(i * 16), 32'd1);
        s_req = 4'b1111;
        order2 = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            npc_grant(order2[k], 0, 1'b0, w);
            check("t2_gap", 64'(w), 64'd1);
            if (k == 4) s_req = '0;
            npc_acks(order2[k], 1, 0);
            check("t2_idle_after", 64'(m_req), 64'd0);
        end

        // 3) master 2 write, len 3, wdt changes each ack
        set_master(2, 1'b0, 32'h0000_3000, 32'd3);
        base0 = ack_cnt[2];
        s_req = 4'b0100;
        npc_grant(2, 1, 1'b1, w);
        npc_acks(2, 3, 1);
        check("t3_ack_cnt", 64'(ack_cnt[2] - base0), 64'd3);
        check("t3_own", 64'(own), 64'd0);

        // 4) zero-length burst from master 1, then ptr must be 2
        set_master(1, 1'b1, 32'h0000_4000, 32'd0);
        base0 = ack_cnt[1];
        s_req = 4'b0010;
        npc_grant(1, 2, 1'b1, w);
        check("t4_own_clr", 64'(own), 64'd0);
        check("t4_idle", 64'(m_req), 64'd0);
        tick();
        check("t4_no_rereq", 64'(m_req), 64'd0);
        check("t4_no_ack", 64'(ack_cnt[1] - base0), 64'd0);
        for (int i = 1; i < N; i++) set_master(i, 1'b1, 32'h4100 + 32'(i * 16), 32'd1);
        s_req = 4'b1110;
        order4 = '{2, 3, 1};
        for (int k = 0; k < 3; k++) begin
            npc_grant(order4[k], 0, 1'b1, w);
            npc_acks(order4[k], 1, 0);
        end

        // 5) reset mid-burst after two acks
        set_master(0, 1'b1, 32'h0000_5000, 32'd5);
        s_req = 4'b0001;
        npc_grant(0, 0, 1'b1, w);
        npc_acks(0, 2, 0);
        base0 = ack_cnt[0];
        check("t5_own_pre", 64'(own), 64'b0001);
        m_ack = 1'b1;
        rstn  = 1'b0;
        #1;
        check("t5_own_rst", 64'(own), 64'd0);
        check("t5_mreq_rst", 64'(m_req), 64'd0);
        check("t5_sack_rst", 64'(s_ack), 64'd0);
        tick();
        rstn = 1'b1;
        repeat (3) tick();
        m_ack = 1'b0;
        check("t5_no_acks", 64'(ack_cnt[0] - base0), 64'd0);
        check("t5_own_post", 64'(own), 64'd0);

        // 6) ack stalls after one word
        set_master(3, 1'b1, 32'h0000_6000, 32'd4);
        set_master(1, 1'b1, 32'h0000_6100, 32'd1);
        s_req = 4'b1000;
        npc_grant(3, 0, 1'b1, w);
        s_req[1] = 1'b1;
        npc_acks(3, 1, 0);
        wd_t = 0;
        wd_seen = 1'b0;
`ifdef NPC_ARB_WDOG_EN
        while (!wd_seen && wd_t < 40) begin
            tick();
            wd_t++;
            wd_seen = wd_err;
        end
        check("t6_wd_cycles", 64'(wd_t), 64'd16);
        check("t6_own_rel", 64'(own), 64'd0);
        tick();
        check("t6_wd_pulse", 64'(wd_err), 64'd0);
        base0 = ack_cnt[3];
        npc_grant(1, 0, 1'b1, w);
        check("t6_no_more_acks", 64'(ack_cnt[3] - base0), 64'd0);
`else
        for (int t = 0; t < 40; t++) begin
            tick();
            if (wd_err) wd_seen = 1'b1;
        end
        check("t6_no_wd_err", 64'(wd_seen), 64'd0);
        check("t6_own_held", 64'(own), 64'b1000);
        npc_acks(3, 3, 0);
        npc_grant(1, 0, 1'b1, w);
`endif
        npc_acks(1, 1, 0);
        tick();
        check("end_gq_empty", 64'(gq.size()), 64'd0);
        check("end_aq_empty", 64'(aq.size()), 64'd0);
        check("end_own", 64'(own), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
